// File: rtl/c_lfsr_bank_pkg.sv
// Shared types and helpers for the multi-channel LFSR/MISR bank.
package c_lfsr_bank_pkg;

   // Always at least one bit wide, so single-channel builds still get a legal index port.
   function automatic int clog2(input int value);
      return (value <= 2) ? 1 : $clog2(value);
   endfunction

   typedef enum logic {
      LFSR_FREE,
      LFSR_MISR
   } lfsr_mode_e;

   // Internal step count, wide enough for any practical max_iterations.
   localparam int step_cnt_w = 8;
   typedef logic [step_cnt_w-1:0] step_cnt_t;

endpackage

// File: rtl/c_lfsr_step.sv
// Combinational F^k for k = 0..max_iterations: an unrolled step chain and a mux on the step count.
module c_lfsr_step
   import c_lfsr_bank_pkg::*;
#(
   parameter int width          = 16,
   parameter int max_iterations = 4
) (
   input  logic [0:width-1] state,
   input  logic [0:width-1] poly,
   input  logic             complete,
   input  step_cnt_t        steps,
   output logic [0:width-1] result
);

   // Index 0 is the MSB; complete mode injects the all-zeros state after 10...0.
   function automatic logic [0:width-1] step_once(input logic [0:width-1] s,
                                                   input logic [0:width-1] p,
                                                   input logic             c);
      logic fb;
      fb = s[0] ^ (c & ~|s[1:width-1]);
      return {s[1:width-1], 1'b0} ^ (fb ? p : '0);
   endfunction

   logic [0:width-1] taps [0:max_iterations];

   assign taps[0] = state;

   for (genvar i = 0; i < max_iterations; i++) begin : g_chain
      logic [0:width-1] nxt;
      if (i == 0) begin : g_first
         assign nxt = step_once(state, poly, complete);
      end else begin : g_rest
         assign nxt = step_once(g_chain[i-1].nxt, poly, complete);
      end
      assign taps[i+1] = nxt;
   end

   // NOTE: result is defaulted before the loop so no path leaves it unassigned (no latch).
   always_comb begin
      result = taps[0];
      for (int i = 1; i <= max_iterations; i++) begin
         if (steps == step_cnt_t'(i)) result = taps[i];
      end
   end

endmodule

// File: rtl/c_lfsr_bank.sv
// Multi-channel LFSR/MISR engine: per-channel state, shared polynomial, two-stage step pipeline.
module c_lfsr_bank
   import c_lfsr_bank_pkg::*;
#(
   parameter int               width          = 16,
   parameter int               num_channels   = 4,
   parameter int               max_iterations = 4,
   parameter logic [0:width-1] reset_poly     = 16'h002D,
   parameter logic [0:width-1] reset_seed     = 16'h0001
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic                                  cfg_we,
   input  logic [0:width-1]                      cfg_poly,
   input  logic                                  cfg_complete,
   input  logic                                  seed_we,
   input  logic [clog2(num_channels)-1:0]        seed_chan,
   input  logic [0:width-1]                      seed_data,
   input  logic                                  req_valid,
   output logic                                  req_ready,
   input  logic [clog2(num_channels)-1:0]        req_chan,
   input  logic [clog2(max_iterations+1)-1:0]    req_steps,
   input  logic                                  req_misr,
   input  logic [0:width-1]                      req_data,
   output logic                                  resp_valid,
   output logic [clog2(num_channels)-1:0]        resp_chan,
   output logic [0:width-1]                      resp_state
);

   localparam int chan_w = clog2(num_channels);

   logic [0:width-1] poly_q;
   logic             complete_q;
   logic [0:width-1] state_q [num_channels];

   logic             s1_valid;
   logic [chan_w-1:0] s1_chan;
   step_cnt_t        s1_steps;
   lfsr_mode_e       s1_mode;
   logic [0:width-1] s1_data;
   logic [0:width-1] s1_poly;
   logic             s1_complete;

   logic             accept;
   step_cnt_t        steps_clamped;
   logic [0:width-1] stepped;
   logic [0:width-1] new_state;

   assign req_ready = ~cfg_we & ~(seed_we & (seed_chan == req_chan));
   assign accept    = req_valid & req_ready;

   assign steps_clamped = (step_cnt_t'(req_steps) > step_cnt_t'(max_iterations))
                        ? step_cnt_t'(max_iterations) : step_cnt_t'(req_steps);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         poly_q     <= reset_poly;
         complete_q <= 1'b0;
      end else if (cfg_we) begin
         poly_q     <= cfg_poly;
         complete_q <= cfg_complete;
      end
   end

   // Poly/complete travel with the request so a later cfg_we cannot affect it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_valid    <= 1'b0;
         s1_chan     <= '0;
         s1_steps    <= '0;
         s1_mode     <= LFSR_FREE;
         s1_data     <= '0;
         s1_poly     <= '0;
         s1_complete <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         s1_valid <= accept;
         if (accept) begin
            s1_chan     <= req_chan;
            s1_steps    <= steps_clamped;
            s1_mode     <= req_misr ? LFSR_MISR : LFSR_FREE;
            s1_data     <= req_data;
            s1_poly     <= poly_q;
            s1_complete <= complete_q;
         end
      end
   end

   c_lfsr_step #(
      .width          (width),
      .max_iterations (max_iterations)
   ) u_step (
      .state    (state_q[s1_chan]),
      .poly     (s1_poly),
      .complete (s1_complete),
      .steps    (s1_steps),
      .result   (stepped)
   );

   assign new_state = stepped ^ ((s1_mode == LFSR_MISR) ? s1_data : '0);

   // NOTE: the state array is flops, not RAM, because every channel must reset asynchronously to reset_seed.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int ch = 0; ch < num_channels; ch++) state_q[ch] <= reset_seed;
      end else begin
         for (int ch = 0; ch < num_channels; ch++) begin
            if (seed_we && seed_chan == chan_w'(ch))
               state_q[ch] <= seed_data;
            else if (s1_valid && s1_chan == chan_w'(ch))
               state_q[ch] <= new_state;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         resp_valid <= 1'b0;
         resp_chan  <= '0;
         resp_state <= '0;
      end else begin
         resp_valid <= s1_valid;
         if (s1_valid) begin
            resp_chan  <= s1_chan;
            resp_state <= new_state;
         end
      end
   end

   steps_in_range: assert property (@(posedge clk) disable iff (!reset)
      accept |-> (step_cnt_t'(req_steps) <= step_cnt_t'(max_iterations)));

endmodule

// File: tb/tb_c_lfsr_bank.sv
// Directed bench for c_lfsr_bank: width=4, four channels, up to four steps, poly 4'b0011.
module tb_c_lfsr_bank;

   logic       clk = 1'b0;
   logic       reset;
   logic       cfg_we;
   logic [0:3] cfg_poly;
   logic       cfg_complete;
   logic       seed_we;
   logic [1:0] seed_chan;
   logic [0:3] seed_data;
   logic       req_valid;
   logic       req_ready;
   logic [1:0] req_chan;
   logic [2:0] req_steps;
   logic       req_misr;
   logic [0:3] req_data;
   logic       resp_valid;
   logic [1:0] resp_chan;
   logic [0:3] resp_state;

   int n_checks = 0;
   int n_pass   = 0;

   c_lfsr_bank #(
      .width          (4),
      .num_channels   (4),
      .max_iterations (4),
      .reset_poly     (4'b0011),
      .reset_seed     (4'b0001)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .cfg_we       (cfg_we),
      .cfg_poly     (cfg_poly),
      .cfg_complete (cfg_complete),
      .seed_we      (seed_we),
      .seed_chan    (seed_chan),
      .seed_data    (seed_data),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_chan     (req_chan),
      .req_steps    (req_steps),
      .req_misr     (req_misr),
      .req_data     (req_data),
      .resp_valid   (resp_valid),
      .resp_chan    (resp_chan),
      .resp_state   (resp_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got %b expected %b", tag, got, exp);
      else n_pass++;
   endtask

   task automatic seed(input logic [1:0] ch, input logic [0:3] val);
      seed_we = 1'b1; seed_chan = ch; seed_data = val;
      @(posedge clk); @(negedge clk);
      seed_we = 1'b0;
   endtask

   // Issue one request and check the response lands exactly one edge after the accept edge.
   task automatic request(input string tag, input logic [1:0] ch, input logic [2:0] steps,
                          input logic misr, input logic [0:3] data, input logic [0:3] exp);
      req_valid = 1'b1; req_chan = ch; req_steps = steps; req_misr = misr; req_data = data;
      #1 check({tag, ".ready"}, 8'(req_ready), 8'd1);
      @(posedge clk); @(negedge clk);
      req_valid = 1'b0;
      check({tag, ".early"}, 8'(resp_valid), 8'd0);
      @(posedge clk); @(negedge clk);
      check({tag, ".valid"}, 8'(resp_valid), 8'd1);
      check({tag, ".chan"},  8'(resp_chan),  8'(ch));
      check({tag, ".state"}, 8'(resp_state), 8'(exp));
   endtask

   logic [0:3] b2b_exp [4];

   initial begin
      b2b_exp[0] = 4'b0010; b2b_exp[1] = 4'b0100; b2b_exp[2] = 4'b1000; b2b_exp[3] = 4'b0011;
      reset = 1'b0; cfg_we = 1'b0; cfg_poly = '0; cfg_complete = 1'b0;
      seed_we = 1'b0; seed_chan = '0; seed_data = '0;
      req_valid = 1'b0; req_chan = '0; req_steps = '0; req_misr = 1'b0; req_data = '0;
      repeat (2) @(negedge clk);
      check("rst.resp_valid", 8'(resp_valid), 8'd0);
      check("rst.resp_chan",  8'(resp_chan),  8'd0);
      check("rst.resp_state", 8'(resp_state), 8'd0);
      reset = 1'b1;
      @(negedge clk);

      // Reset seed visible on every channel, then the first step from 1000.
      for (int ch = 0; ch < 4; ch++) request("rst.seed", 2'(ch), 3'd0, 1'b0, 4'b0, 4'b0001);
      seed(2'd0, 4'b1000);
      request("t1", 2'd0, 3'd1, 1'b0, 4'b0, 4'b0011);

      // Complete mode walks 1000 -> 0000 -> 0011; cfg_we blocks acceptance.
      cfg_we = 1'b1; cfg_poly = 4'b0011; cfg_complete = 1'b1; req_valid = 1'b1; req_chan = 2'd3;
      #1 check("cfg.ready", 8'(req_ready), 8'd0);
      @(posedge clk); @(negedge clk);
      cfg_we = 1'b0; req_valid = 1'b0;
      check("cfg.no_accept", 8'(resp_valid), 8'd0);
      seed(2'd1, 4'b1000);
      request("t2.a", 2'd1, 3'd1, 1'b0, 4'b0, 4'b0000);
      request("t2.b", 2'd1, 3'd1, 1'b0, 4'b0, 4'b0011);
      cfg_we = 1'b1; cfg_complete = 1'b0;
      @(posedge clk); @(negedge clk);
      cfg_we = 1'b0;
      seed(2'd1, 4'b0000);
      request("t2.lock", 2'd1, 3'd3, 1'b0, 4'b0, 4'b0000);

      // Four back-to-back single steps on ch2 against one four-step request on ch3.
      seed(2'd2, 4'b0001);
      seed(2'd3, 4'b0001);
      for (int i = 0; i < 6; i++) begin
         if (i == 1) check("t3.gap", 8'(resp_valid), 8'd0);
         if (i >= 2) begin
            check("t3.valid", 8'(resp_valid), 8'd1);
            check("t3.state", 8'(resp_state), 8'(b2b_exp[i-2]));
         end
         req_valid = (i < 4); req_chan = 2'd2; req_steps = 3'd1; req_misr = 1'b0;
         @(posedge clk); @(negedge clk);
      end
      check("t3.drain", 8'(resp_valid), 8'd0);
      request("t3.single", 2'd3, 3'd4, 1'b0, 4'b0, 4'b0011);

      // MISR mode: data folded in after stepping.
      seed(2'd0, 4'b0001);
      request("t4.zero", 2'd0, 3'd0, 1'b1, 4'b0110, 4'b0111);
      seed(2'd0, 4'b0001);
      request("t4.two", 2'd0, 3'd2, 1'b1, 4'b0000, 4'b0100);
      request("t4.one", 2'd0, 3'd1, 1'b1, 4'b0000, 4'b1000);
      request("t4.data", 2'd0, 3'd1, 1'b1, 4'b0101, 4'b0110);

      // Seed collisions: same-channel seed stalls, other-channel seed does not.
      req_valid = 1'b1; req_chan = 2'd1; req_steps = 3'd0; req_misr = 1'b0;
      seed_we = 1'b1; seed_chan = 2'd1; seed_data = 4'b0110;
      #1 check("t5.ready_same", 8'(req_ready), 8'd0);
      seed_chan = 2'd2;
      #1 check("t5.ready_other", 8'(req_ready), 8'd1);
      req_valid = 1'b0;
      seed_chan = 2'd1; seed_data = 4'b0101;
      @(posedge clk); @(negedge clk);
      seed_we = 1'b0;
      // Writeback and seed on the same edge: seed kept, response shows the computed value.
      req_valid = 1'b1; req_chan = 2'd1; req_steps = 3'd1; req_misr = 1'b0;
      @(posedge clk); @(negedge clk);
      req_valid = 1'b0;
      seed_we = 1'b1; seed_chan = 2'd1; seed_data = 4'b1100;
      @(posedge clk); @(negedge clk);
      seed_we = 1'b0;
      check("t5.wb_resp", 8'(resp_state), 8'b1010);
      request("t5.seed_wins", 2'd1, 3'd0, 1'b0, 4'b0, 4'b1100);

      // Reset with a request in stage 1 discards it and restores every seed.
      seed(2'd0, 4'b1111);
      req_valid = 1'b1; req_chan = 2'd0; req_steps = 3'd1; req_misr = 1'b0;
      @(posedge clk); @(negedge clk);
      req_valid = 1'b0;
      reset = 1'b0;
      #1 check("t6.no_resp", 8'(resp_valid), 8'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("t6.after", 8'(resp_valid), 8'd0);
      for (int ch = 0; ch < 4; ch++) request("t6.seed", 2'(ch), 3'd0, 1'b0, 4'b0, 4'b0001);
      request("t6.step", 2'd0, 3'd1, 1'b0, 4'b0, 4'b0010);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
